// File: rtl/tl_arb_v1.sv
// tl_arb_v1: age-based N-way arbiter from per-core TileLink A-channel requesters
// onto one shared request path, plus source-routed D-channel response fan-out.
// The shared channel record types live in the package at the top of this file.

package tl_arb_pkg;

    // A-channel record, 76 bits, MSB first.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  source;
        logic        valid;
        logic        ready;
    } tl_a_channel;

    // D-channel record, 73 bits, MSB first.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  source;
        logic        valid;
        logic        ready;
    } tl_d_channel;

endpackage

module tl_arb_v1
    import tl_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int AGE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,                // active-high asynchronous reset despite the name
    input  tl_a_channel req     [NUM_CORES],
    output tl_a_channel win_req,
    output logic [NUM_CORES-1:0] ack,
    input  logic        a_ready,
    output logic        d_ready,
    input  logic        d_valid,
    input  tl_d_channel resp,
    output tl_d_channel c_resp  [NUM_CORES]
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    logic [AGE_WIDTH-1:0] age_reg  [NUM_CORES];
    logic [AGE_WIDTH-1:0] age_next [NUM_CORES];
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant_vec;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [AGE_WIDTH-1:0] best_age;
    logic                 grant;
    tl_a_channel          win_req_next;

    // Per-core eligibility and next wait-age. A core that was just acked is
    // masked for one cycle so it cannot be re-granted before it drops valid.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign eligible[gi] = req[gi].valid & ~ack[gi];
            assign age_next[gi] = (grant_vec[gi] || !req[gi].valid) ? '0 :
                                  (eligible[gi] && age_reg[gi] != AGE_MAX) ? age_reg[gi] + 1'b1 :
                                  age_reg[gi];
        end
    endgenerate

    // Oldest eligible core wins; strict compare keeps ties on the lowest index.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        best_age  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (eligible[i] && (!win_found || age_reg[i] > best_age)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                best_age  = age_reg[i];
            end
        end
    end

    assign grant     = a_ready & win_found;
    assign grant_vec = grant ? (NUM_CORES'(1) << win_idx) : '0;

    // Winner's request as it will appear downstream, valid forced high.
    always_comb begin
        win_req_next = '0;
        if (grant) begin
            win_req_next       = req[win_idx];
            win_req_next.valid = 1'b1;
        end
    end

    // Wait-age counters.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CORES; i++) age_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) age_reg[i] <= age_next[i];
        end
    end

    // Registered grant: win_req and one-hot ack pulse for one cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win_req <= '0;
            ack     <= '0;
        end else begin
            win_req <= win_req_next;
            ack     <= grant_vec;
        end
    end

    // Response path: steer accepted response to its source lane; other lanes
    // keep their payload but drop valid. Out-of-range sources match no lane.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            d_ready <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) c_resp[k] <= '0;
        end else begin
            d_ready <= 1'b1;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (d_valid && d_ready && resp.source == 4'(k)) begin
                    c_resp[k]       <= resp;
                    c_resp[k].valid <= 1'b1;
                end else begin
                    c_resp[k].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tl_arb_v1.sv
// Randomized scoreboard bench for tl_arb_v1: a reference model pushes expected
// grants and responses into queues; a monitor pops them when they come due.

module tb_tl_arb_v1;
    import tl_arb_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int AMAX = (1 << AW) - 1;

    logic        clk;
    logic        rst_n;
    tl_a_channel req [N];
    tl_a_channel win_req;
    logic [N-1:0] ack;
    logic        a_ready;
    logic        d_ready;
    logic        d_valid;
    tl_d_channel resp;
    tl_d_channel c_resp [N];

    tl_arb_v1 #(.NUM_CORES(N), .AGE_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .win_req (win_req),
        .ack     (ack),
        .a_ready (a_ready),
        .d_ready (d_ready),
        .d_valid (d_valid),
        .resp    (resp),
        .c_resp  (c_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [N-1:0] ack;
        tl_a_channel wr;
    } gexp_t;

    typedef struct {
        int          cyc;
        int          lane;
        tl_d_channel d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: wait time per core in cycles, last grant, response readiness.
    int           m_wait [N];
    logic [N-1:0] m_ack    = '0;
    logic         m_dr     = 1'b0;
    logic         m_active = 1'b0;

    // Reference model: oldest-waiting eligible core wins each accepting edge.
    always @(posedge clk) begin
        int best;
        gexp_t g;
        rexp_t r;
        cyc++;
        if (rst_n) begin
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_ack    = '0;
            m_dr     = 1'b0;
            m_active = 1'b0;
        end else begin
            m_active = 1'b1;
            best = -1;
            for (int i = 0; i < N; i++)
                if (req[i].valid && !m_ack[i] && (best < 0 || m_wait[i] > m_wait[best]))
                    best = i;
            if (!a_ready) best = -1;
            for (int i = 0; i < N; i++) begin
                if (i == best || !req[i].valid) m_wait[i] = 0;
                else if (!m_ack[i] && m_wait[i] < AMAX) m_wait[i] = m_wait[i] + 1;
            end
            if (best >= 0) begin
                g.cyc = cyc;
                g.wr = req[best];
                g.wr.valid = 1'b1;
                g.ack = N'(1) << best;
                gq.push_back(g);
                m_ack = g.ack;
            end else begin
                m_ack = '0;
            end
            if (d_valid && m_dr && int'(resp.source) < N) begin
                r.cyc = cyc;
                r.lane = int'(resp.source);
                r.d = resp;
                r.d.valid = 1'b1;
                rq.push_back(r);
            end
            m_dr = 1'b1;
        end
    end

    // Monitor: compares DUT outputs against due queue entries, flags strays.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        int lane;
        if (!rst_n && m_active) begin
            n_tests++;
            if (d_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL d_ready cyc=%0d: got %b want 1", cyc, d_ready);
            end
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                g = gq.pop_front();
                n_tests++;
                if (ack !== g.ack || win_req !== g.wr) begin
                    n_fail++;
                    $display("FAIL grant cyc=%0d: got ack=%b win_req=%h want ack=%b win_req=%h",
                             cyc, ack, win_req, g.ack, g.wr);
                end else begin
                    $display("[TB] cyc=%0d grant ack=%b src=%0d op=%0d", cyc, ack, win_req.source, win_req.opcode);
                end
            end else if (ack !== '0 || win_req !== '0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_grant cyc=%0d: got ack=%b win_req=%h want none", cyc, ack, win_req);
            end
            lane = -1;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                lane = r.lane;
                n_tests++;
                if (c_resp[lane] !== r.d) begin
                    n_fail++;
                    $display("FAIL resp_lane%0d cyc=%0d: got %h want %h", lane, cyc, c_resp[lane], r.d);
                end else begin
                    $display("[TB] cyc=%0d resp lane=%0d data=%h", cyc, lane, c_resp[lane].data);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (k != lane && c_resp[k].valid !== 1'b0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_resp lane%0d cyc=%0d: got valid=%b want 0", k, cyc, c_resp[k].valid);
                end
            end
        end
    end

    task automatic chk_reset(input string nm);
        logic ok;
        ok = (ack === '0) && (win_req === '0) && (d_ready === 1'b0);
        for (int k = 0; k < N; k++) if (c_resp[k] !== '0) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got ack=%b win_req=%h d_ready=%b c_resp0=%h want all zero",
                     nm, ack, win_req, d_ready, c_resp[0]);
        end else begin
            $display("[TB] %s outputs cleared", nm);
        end
    endtask

    function automatic tl_a_channel rand_a(input int src);
        tl_a_channel a;
        a.opcode  = 3'($urandom);
        a.param   = 3'($urandom);
        a.address = $urandom;
        a.data    = $urandom;
        a.source  = 4'(src);
        a.valid   = 1'b1;
        a.ready   = 1'($urandom);
        return a;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) req[i] = '0;
        a_ready = 1'b0;
        d_valid = 1'b0;
        resp    = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One cycle of random traffic; requesters sometimes hold valid after ack.
    task automatic rand_cycle();
        for (int i = 0; i < N; i++) begin
            if (req[i].valid && ack[i] && $urandom_range(0, 1) == 1) req[i].valid = 1'b0;
            else if (!req[i].valid && $urandom_range(0, 3) == 0) req[i] = rand_a(i);
        end
        a_ready = ($urandom_range(0, 3) != 0);
        d_valid = $urandom_range(0, 1) == 1;
        resp.opcode  = 3'($urandom);
        resp.address = $urandom;
        resp.data    = $urandom;
        resp.source  = 4'($urandom_range(0, 15));
        resp.valid   = 1'($urandom);
        resp.ready   = 1'($urandom);
        step(1);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b1;
        idle_inputs();
        step(3);
        chk_reset("reset_state");
        rst_n = 1'b0;
        step(2);

        // Single request from core 1; valid kept one cycle past ack, then dropped.
        req[1] = '0;
        req[1].opcode = 3'b101;
        req[1].data   = 32'hFFFF_FFFF;
        req[1].source = 4'd1;
        req[1].valid  = 1'b1;
        a_ready = 1'b1;
        step(2);
        req[1].valid = 1'b0;
        step(3);

        // Tie-break: cores 0 and 2 together.
        req[0] = rand_a(0);
        req[2] = rand_a(2);
        step(1);
        req[0].valid = 1'b0;
        step(1);
        req[2].valid = 1'b0;
        step(2);

        // Back-pressure on core 2, then release.
        a_ready = 1'b0;
        req[2] = rand_a(2);
        step(5);
        a_ready = 1'b1;
        step(1);
        req[2].valid = 1'b0;
        step(2);

        // Saturation: both cores wait long enough to saturate; tie goes to core 0.
        a_ready = 1'b0;
        req[3] = rand_a(3);
        step(300);
        req[0] = rand_a(0);
        step(260);
        a_ready = 1'b1;
        step(1);
        req[0].valid = 1'b0;
        step(1);
        req[3].valid = 1'b0;
        step(2);

        // Response routing to lane 3, then an out-of-range source.
        d_valid = 1'b1;
        resp = '0;
        resp.opcode  = 3'd3;
        resp.address = 32'd3;
        resp.data    = 32'd33;
        resp.source  = 4'd3;
        step(1);
        resp.source  = 4'd9;
        step(1);
        d_valid = 1'b0;
        step(2);

        // Aging fairness under random traffic.
        repeat (2000) rand_cycle();

        // Reset mid-operation while a grant pulse is live.
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            rand_cycle();
            if (ack != '0) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midop_ack_wait: got no ack within 200 cycles want ack");
        end
        #2 rst_n = 1'b1;
        #1 chk_reset("reset_midop");
        gq.delete();
        rq.delete();
        idle_inputs();
        step(2);
        chk_reset("reset_hold");
        rst_n = 1'b0;
        repeat (200) rand_cycle();
        idle_inputs();
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
